vme_slave_fsm: RTL
==================

# vme_slave_fsm

Synchronous VME64 slave front-end that consumes single-cycle D32 transfers issued on the VME backplane and converts them into a local register-bus access. It sits directly downstream of the bus master. It samples AS/DS/WRITE/AM/A/LWORD, decodes the address window, runs a local request/ack handshake, and drives DTACK or BERR back to the master. Block transfers, A64 and 2eSST are out of scope.

## Interface
Parameters:
- G_TIMEOUT, 255: local-bus cycles to wait for ack/err before BERR (8-bit counter).
- G_SYNC_STAGES, 2: flip-flop stages on AS_n, DS_n[1:0], WRITE_n.

Ports:
- clk_i  in  1  system clock; only clock.
- rst_i  in  1  reset, synchronous, active-high.
- vme_as_n_i  in  1  address strobe.
- vme_ds_n_i  in  2  data strobes {DS1,DS0}.
- vme_write_n_i  in  1  0 = write.
- vme_am_i  in  6  address modifier.
- vme_addr_i  in  31  A[31:1].
- vme_lword_n_i  in  1  LWORD.
- vme_data_i  in  32  D[31:0] from bus.
- vme_data_o  out  32  read data to bus.
- vme_data_oe_o  out  1  data bus drive enable.
- vme_dtack_n_o  out  1  DTACK, open-drain style, 1 = released.
- vme_berr_n_o  out  1  BERR, 1 = released.
- base_a32_i  in  8  A32 window base, compared to A[31:24].
- base_a24_i  in  8  A24 window base, compared to A[23:16].
- loc_cyc_o  out  1  local request, held until ack/err/timeout.
- loc_we_o  out  1  local write.
- loc_adr_o  out  24  byte address inside window, A[23:2] & 00.
- loc_dat_o  out  32  write data.
- loc_dat_i  in  32  read data, valid with loc_ack_i.
- loc_ack_i  in  1  local completion.
- loc_err_i  in  1  local error; produces BERR.

## Operation
- AS_n, DS_n and WRITE_n pass through G_SYNC_STAGES flops. AM, A, LWORD and D are sampled raw, only when synchronized AS_n is low. They are stable by bus protocol.
- FSM states:
  - IDLE: synchronized AS_n falling edge → DECODE.
  - DECODE: latch AM/A/LWORD/WRITE_n. Hit when both hold:
    - AM ∈ {0x09,0x0D} and A[31:24]==base_a32_i, or (A24 mode) AM ∈ {0x39,0x3D} and A[23:16]==base_a24_i.
    - A[1]==0.
  - Miss → WAIT_AS, with no bus response, so the master times out.
  - Hit → WAIT_DS.
- WAIT_DS:
  - Both synchronized DS_n low: LWORD_n==0 → REQ, latching D on a write. Otherwise → BERR (only D32 is supported).
  - AS_n rises first → IDLE.
- REQ:
  - loc_cyc_o=1, with loc_we_o and loc_adr_o/loc_dat_o stable.
  - loc_ack_i → latch loc_dat_i into vme_data_o, drop cyc → ACK.
  - loc_err_i, or counter==G_TIMEOUT → drop cyc → BERR. Ack wins if ack and err arrive together.
- ACK: read sets vme_data_oe_o=1 one cycle before vme_dtack_n_o=0. Write sets DTACK the cycle after entry. Stay until both synchronized DS_n are high → REL.
- BERR: vme_berr_n_o=0 until both DS_n are high → REL.
- REL: release DTACK/BERR/data_oe; → WAIT_AS.
- WAIT_AS: wait for synchronized AS_n high → IDLE. A new AS falling edge is accepted only from IDLE.

## Timing
- Reset values: vme_dtack_n_o=1, vme_berr_n_o=1, vme_data_oe_o=0, vme_data_o=0, loc_cyc_o=0, loc_we_o=0, loc_adr_o=0, loc_dat_o=0; FSM in IDLE; timeout counter=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Latency with G_SYNC_STAGES=2, counted from the clock edge at which raw DS_n is first sampled low to loc_cyc_o=1: 3 cycles.
- Latency from loc_ack_i to DTACK low: write 1 cycle; read 2 cycles, with data_oe taking the first.
- DTACK and data_oe release in the same cycle: 1 cycle after synchronized DS_n high, i.e. the REL cycle.
- Timeout counter starts at 0 on REQ entry and increments every REQ cycle. loc_cyc_o is held at most G_TIMEOUT+1 cycles.
- rst_i asserted mid-transfer: every output returns to its reset value on the next edge and the local request is abandoned. After reset the FSM waits for AS_n high before accepting a new cycle; it enters WAIT_AS if AS_n is low.

## Configuration
- VME_SLAVE_A24_EN defined: AM 0x39/0x3D with the base_a24_i compare is decoded.
- VME_SLAVE_A24_EN undefined: only A32 AMs hit. base_a24_i is unused and A24 cycles get no response.

## Test plan
- A32 write, AM=0x09, A=0x12000010, D=0xDEADBEEF, base_a32_i=0x12 → one loc_cyc_o pulse with loc_we_o=1, loc_adr_o=0x000010, loc_dat_o=0xDEADBEEF. DTACK low until DS high, then released.
- A32 read, AM=0x0D, A=0x12000020, loc_dat_i=0xCAFEF00D ack after 5 cycles → vme_data_o=0xCAFEF00D and data_oe=1 one cycle before DTACK=0.
- Address miss, A=0x13000000 → no loc_cyc_o, DTACK/BERR stay 1, FSM back in IDLE after AS high.
- Local stall, loc_ack_i never asserted, G_TIMEOUT=255 → loc_cyc_o high for 256 cycles, then BERR=0 until DS release.
- D16 attempt with LWORD_n=1 on a hit → BERR, no loc_cyc_o. loc_err_i=1 on a hit → BERR.
- rst_i pulsed during REQ → all outputs at reset values next edge. A following A24 access (AM=0x39, A[23:16]=base_a24_i) hits only with VME_SLAVE_A24_EN defined.

Source files
------------

// File: rtl/vme_slave_fsm.sv
// ---------------------------------------------------------------------------
// vme_slave_fsm
// VME64 slave front-end for single-cycle D32 transfers. Synchronizes the
// bus strobes, decodes the A32 (and optionally A24) address window, runs a
// request/ack handshake on the local register bus and answers the master
// with DTACK or BERR.
//
// Build option:
//   VME_SLAVE_A24_EN  when defined, AM 0x39/0x3D compared against
//                     base_a24_i also hit; otherwise only A32 AMs hit and
//                     base_a24_i is ignored.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   vme_as_n_i, vme_ds_n_i,
//   vme_write_n_i                bus strobes (synchronized internally)
//   vme_am_i, vme_addr_i (A31:1),
//   vme_lword_n_i, vme_data_i    bus qualifiers/data (sampled raw)
//   vme_data_o, vme_data_oe_o    read data and its drive enable
//   vme_dtack_n_o, vme_berr_n_o  bus responses, 1 = released
//   base_a32_i, base_a24_i       window bases
//   loc_cyc_o, loc_we_o,
//   loc_adr_o, loc_dat_o         local request
//   loc_dat_i, loc_ack_i,
//   loc_err_i                    local completion
// ---------------------------------------------------------------------------
module vme_slave_fsm #(
  parameter int G_TIMEOUT     = 255,
  parameter int G_SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        vme_as_n_i,
  input  logic [1:0]  vme_ds_n_i,
  input  logic        vme_write_n_i,
  input  logic [5:0]  vme_am_i,
  input  logic [30:0] vme_addr_i,
  input  logic        vme_lword_n_i,
  input  logic [31:0] vme_data_i,
  output logic [31:0] vme_data_o,
  output logic        vme_data_oe_o,
  output logic        vme_dtack_n_o,
  output logic        vme_berr_n_o,
  input  logic [7:0]  base_a32_i,
  input  logic [7:0]  base_a24_i,
  output logic        loc_cyc_o,
  output logic        loc_we_o,
  output logic [23:0] loc_adr_o,
  output logic [31:0] loc_dat_o,
  input  logic [31:0] loc_dat_i,
  input  logic        loc_ack_i,
  input  logic        loc_err_i
);

  // state    | meaning
  // IDLE     | waiting for a synchronized AS_n falling edge
  // DECODE   | latch address qualifiers, check the window
  // WAIT_DS  | hit; waiting for both data strobes
  // REQ      | local request outstanding, timeout counter running
  // ACK      | local ack seen; present data (read) then DTACK
  // BERR     | error, timeout or unsupported width; BERR asserted
  // REL      | release DTACK/BERR/data enable
  // WAIT_AS  | waiting for AS_n high before a new cycle may start
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT_DS, S_REQ, S_ACK, S_BERR, S_REL, S_WAIT_AS
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(G_TIMEOUT);

  state_t r_state;

  logic [G_SYNC_STAGES-1:0] r_as_sync;
  logic [G_SYNC_STAGES-1:0] r_wr_sync;
  logic [1:0]               r_ds_sync [G_SYNC_STAGES];

  logic        w_as_s;
  logic        w_wr_n_s;
  logic [1:0]  w_ds_s;
  logic        w_hit_a32;
  logic        w_hit_a24;
  logic        w_hit;

  logic        r_as_prev;
  logic        r_ds_lo;
  logic [7:0]  r_cnt;
  logic [21:0] r_addr;
  logic        r_lword_n;
  logic        r_write_n;

  logic [31:0] r_rdata;
  logic        r_oe;
  logic        r_dtack_n;
  logic        r_berr_n;
  logic        r_cyc;
  logic        r_we;
  logic [23:0] r_adr;
  logic [31:0] r_wdat;

  // AS_n chain resets to "asserted" so that a cycle already in progress
  // when reset lifts is never mistaken for a fresh falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_as_sync <= '0;
      r_wr_sync <= '1;
      for (int i = 0; i < G_SYNC_STAGES; i++) r_ds_sync[i] <= 2'b11;
    end else begin
      r_as_sync[0] <= vme_as_n_i;
      r_wr_sync[0] <= vme_write_n_i;
      r_ds_sync[0] <= vme_ds_n_i;
      for (int i = 1; i < G_SYNC_STAGES; i++) begin
        r_as_sync[i] <= r_as_sync[i-1];
        r_wr_sync[i] <= r_wr_sync[i-1];
        r_ds_sync[i] <= r_ds_sync[i-1];
      end
    end
  end

  assign w_as_s   = r_as_sync[G_SYNC_STAGES-1];
  assign w_wr_n_s = r_wr_sync[G_SYNC_STAGES-1];
  assign w_ds_s   = r_ds_sync[G_SYNC_STAGES-1];

  // vme_addr_i[k] carries A[k+1].
  assign w_hit_a32 = ((vme_am_i == 6'h09) || (vme_am_i == 6'h0D)) &&
                     (vme_addr_i[30:23] == base_a32_i);
`ifdef VME_SLAVE_A24_EN
  assign w_hit_a24 = ((vme_am_i == 6'h39) || (vme_am_i == 6'h3D)) &&
                     (vme_addr_i[22:15] == base_a24_i);
`else
  logic w_unused_a24;
  assign w_unused_a24 = ^base_a24_i;
  assign w_hit_a24    = 1'b0;
`endif
  assign w_hit = (w_hit_a32 || w_hit_a24) && !vme_addr_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_as_prev <= 1'b0;
      r_ds_lo   <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_lword_n <= 1'b1;
      r_write_n <= 1'b1;
      r_rdata   <= '0;
      r_oe      <= 1'b0;
      r_dtack_n <= 1'b1;
      r_berr_n  <= 1'b1;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
    end else begin
      r_as_prev <= w_as_s;
      // DS assertion gets one extra qualification stage so the raw data
      // lines have had a full cycle to settle before a write latches them.
      r_ds_lo   <= (w_ds_s == 2'b00);

      case (r_state)
        S_IDLE: begin
          // AS low without a preceding high (e.g. right after reset) is a
          // cycle we joined late: sit it out.
          if (!w_as_s) r_state <= r_as_prev ? S_DECODE : S_WAIT_AS;
        end

        S_DECODE: begin
          r_addr    <= vme_addr_i[22:1];
          r_lword_n <= vme_lword_n_i;
          r_write_n <= w_wr_n_s;
          r_state   <= w_hit ? S_WAIT_DS : S_WAIT_AS;
        end

        S_WAIT_DS: begin
          if (w_as_s) begin
            r_state <= S_IDLE;
          end else if (r_ds_lo) begin
            if (!r_lword_n) begin
              r_state <= S_REQ;
              r_cnt   <= '0;
              r_cyc   <= 1'b1;
              r_we    <= !r_write_n;
              r_adr   <= {r_addr, 2'b00};
              if (!r_write_n) r_wdat <= vme_data_i;
            end else begin
              r_state  <= S_BERR;
              r_berr_n <= 1'b0;
            end
          end
        end

        S_REQ: begin
          if (loc_ack_i) begin
            r_cyc   <= 1'b0;
            r_rdata <= loc_dat_i;
            r_state <= S_ACK;
          end else if (loc_err_i || (r_cnt == LP_TIMEOUT)) begin
            r_cyc    <= 1'b0;
            r_berr_n <= 1'b0;
            r_state  <= S_BERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_ACK: begin
          // Reads put data on the bus one cycle ahead of DTACK.
          if (!r_we && !r_oe) begin
            r_oe <= 1'b1;
          end else if (r_dtack_n) begin
            r_dtack_n <= 1'b0;
          end else if (w_ds_s == 2'b11) begin
            r_dtack_n <= 1'b1;
            r_oe      <= 1'b0;
            r_state   <= S_REL;
          end
        end

        S_BERR: begin
          if (w_ds_s == 2'b11) begin
            r_berr_n <= 1'b1;
            r_state  <= S_REL;
          end
        end

        S_REL: begin
          r_dtack_n <= 1'b1;
          r_berr_n  <= 1'b1;
          r_oe      <= 1'b0;
          r_state   <= S_WAIT_AS;
        end

        S_WAIT_AS: begin
          if (w_as_s) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vme_data_o    = r_rdata;
  assign vme_data_oe_o = r_oe;
  assign vme_dtack_n_o = r_dtack_n;
  assign vme_berr_n_o  = r_berr_n;
  assign loc_cyc_o     = r_cyc;
  assign loc_we_o      = r_we;
  assign loc_adr_o     = r_adr;
  assign loc_dat_o     = r_wdat;

endmodule
